// File: rtl/pixel_filler_if.sv
// ============================================================================
//  pixel_filler_if
//  Command and frame-buffer write-port signals of the solid-colour fill engine.
//  The master side is the core plus the write arbiter. The slave side is the
//  engine itself.
//  FILLER_RECT_EN adds the rectangle corner inputs.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pixel_filler_if;
    logic [23:0] filler_color;
    logic        filler_valid;
    logic        filler_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        busy;
`ifdef FILLER_RECT_EN
    logic [9:0]  filler_x0;
    logic [9:0]  filler_y0;
    logic [9:0]  filler_x1;
    logic [9:0]  filler_y1;

    modport master (
        output filler_color, filler_valid, wr_ready,
        output filler_x0, filler_y0, filler_x1, filler_y1,
        input  filler_ready, wr_addr, wr_data, wr_valid, busy
    );
    modport slave (
        input  filler_color, filler_valid, wr_ready,
        input  filler_x0, filler_y0, filler_x1, filler_y1,
        output filler_ready, wr_addr, wr_data, wr_valid, busy
    );
`else
    modport master (
        output filler_color, filler_valid, wr_ready,
        input  filler_ready, wr_addr, wr_data, wr_valid, busy
    );
    modport slave (
        input  filler_color, filler_valid, wr_ready,
        output filler_ready, wr_addr, wr_data, wr_valid, busy
    );
`endif
endinterface

`default_nettype wire

// File: rtl/pixel_filler.sv
// ============================================================================
//  pixel_filler
//  Solid-colour frame-buffer fill engine. It accepts a 24-bit colour command
//  and then emits one 32-bit write beat per pixel of the region, row by row.
//  Optional feature macro: FILLER_RECT_EN. It enables rectangle corner inputs,
//  which are latched on accept. Without it, the region is the full screen.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_filler #(
    parameter int          WIDTH      = 800,
    parameter int          HEIGHT     = 600,
    parameter int          ROW_STRIDE = 1024,
    parameter logic [31:0] FB_BASE    = 32'h1000_0000
) (
    input  logic         clk,
    input  logic         rst,
    pixel_filler_if.slave bus
);

    localparam logic [9:0] X_MAX = 10'(WIDTH - 1);
    localparam logic [9:0] Y_MAX = 10'(HEIGHT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] color;
    logic [9:0]  x_start;
    logic [9:0]  x_end;
    logic [9:0]  y_start;
    logic [9:0]  y_end;
    logic [9:0]  x_ld;
    logic [9:0]  y_ld;
    logic        ready_c;
    logic        valid_c;
    logic        accept;
    logic        beat_done;
    logic        last_beat;
    logic [31:0] row_off;

    assign accept    = (state == IDLE) && bus.filler_valid;
    assign beat_done = (state == FILL) && bus.wr_ready;
    assign last_beat = (x == x_end) && (y == y_end);

`ifdef FILLER_RECT_EN
    logic [9:0] x_hi;
    logic [9:0] y_hi;

    function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // Order the corners, then clamp both ends to the screen.
    always_comb begin
        x_ld = clamp((bus.filler_x0 < bus.filler_x1) ? bus.filler_x0 : bus.filler_x1, X_MAX);
        x_hi = clamp((bus.filler_x0 < bus.filler_x1) ? bus.filler_x1 : bus.filler_x0, X_MAX);
        y_ld = clamp((bus.filler_y0 < bus.filler_y1) ? bus.filler_y0 : bus.filler_y1, Y_MAX);
        y_hi = clamp((bus.filler_y0 < bus.filler_y1) ? bus.filler_y1 : bus.filler_y0, Y_MAX);
    end

    // Region bounds are captured with the command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_start <= '0;
            x_end   <= '0;
            y_start <= '0;
            y_end   <= '0;
        end else if (accept) begin
            x_start <= x_ld;
            x_end   <= x_hi;
            y_start <= y_ld;
            y_end   <= y_hi;
        end
    end
`else
    assign x_ld    = '0;
    assign y_ld    = '0;
    assign x_start = '0;
    assign x_end   = X_MAX;
    assign y_start = '0;
    assign y_end   = Y_MAX;
`endif

    // State register; reset drops wr_valid immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        valid_c   = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.filler_valid) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                valid_c = 1'b1;
                if (bus.wr_ready && last_beat) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // Pixel walker: load on accept, advance raster-order on each completed beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x     <= '0;
            y     <= '0;
            color <= '0;
        end else if (accept) begin
            x     <= x_ld;
            y     <= y_ld;
            color <= bus.filler_color;
        end else if (beat_done && !last_beat) begin
            if (x < x_end) begin
                x <= x + 10'd1;
            end else begin
                x <= x_start;
                y <= y + 10'd1;
            end
        end
    end

    // The row offset is a plain shift for power-of-two strides.
    generate
        if ((ROW_STRIDE & (ROW_STRIDE - 1)) == 0) begin : g_row_shift
            assign row_off = {22'd0, y} << $clog2(ROW_STRIDE);
        end else begin : g_row_mul
            assign row_off = {22'd0, y} * 32'(ROW_STRIDE);
        end
    endgenerate

    assign bus.wr_addr      = FB_BASE + ((row_off + {22'd0, x}) << 2);
    assign bus.wr_data      = {8'h00, color};
    assign bus.wr_valid     = valid_c;
    assign bus.filler_ready = ready_c;
    assign bus.busy         = ~ready_c;

endmodule

`default_nettype wire

// File: tb/tb_pixel_filler.sv
// ============================================================================
//  tb_pixel_filler
//  Directed bench for pixel_filler on a 4x3 screen with a 1024-word stride.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_filler;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    pixel_filler_if bus ();

    pixel_filler #(
        .WIDTH      (4),
        .HEIGHT     (3),
        .ROW_STRIDE (1024),
        .FB_BASE    (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_addr(input int xx, input int yy);
        return BASE + 32'((yy * 1024 + xx) * 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (bus.filler_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", bus.filler_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
        total++; if (bus.wr_valid !== 1'b0) begin bad++; $display("FAIL rst_wr_valid got=%b want=0", bus.wr_valid); end
        total++; if (bus.wr_addr !== BASE) begin bad++; $display("FAIL rst_addr got=%h want=%h", bus.wr_addr, BASE); end
        total++; if (bus.wr_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", bus.wr_data); end
        tick();
        rst = 1'b0;
        bus.wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.wr_valid !== 1'b0 || bus.wr_addr !== BASE) begin
                bad++; $display("FAIL idle_wr_ready valid=%b addr=%h want 0/%h", bus.wr_valid, bus.wr_addr, BASE);
            end
        end
    endtask

    task automatic test_full_fill();
        int cyc;
        bus.filler_color = 24'hFF0000;
        bus.filler_valid = 1'b1;
        bus.wr_ready     = 1'b1;
        tick();
        cyc = 1;
        bus.filler_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            total++; if (bus.wr_valid !== 1'b1 || bus.filler_ready !== 1'b0) begin
                bad++; $display("FAIL full_hs beat=%0d valid=%b ready=%b want 1/0", i, bus.wr_valid, bus.filler_ready);
            end
            total++; if (bus.wr_addr !== exp_addr(i % 4, i / 4)) begin
                bad++; $display("FAIL full_addr beat=%0d got=%h want=%h", i, bus.wr_addr, exp_addr(i % 4, i / 4));
            end
            total++; if (bus.wr_data !== 32'h00FF0000) begin
                bad++; $display("FAIL full_data beat=%0d got=%h want=00ff0000", i, bus.wr_data);
            end
            tick();
            cyc++;
        end
        total++; if (bus.filler_ready !== 1'b1 || bus.busy !== 1'b0 || bus.wr_valid !== 1'b0) begin
            bad++; $display("FAIL full_end ready=%b busy=%b valid=%b want 1/0/0", bus.filler_ready, bus.busy, bus.wr_valid);
        end
        total++; if (cyc != 13) begin bad++; $display("FAIL full_cycles got=%0d want=13", cyc); end
    endtask

    task automatic test_backpressure();
        int beats;
        int cyc;
        logic rdy;
        bus.filler_color = 24'hFF0000;
        bus.filler_valid = 1'b1;
        bus.wr_ready     = 1'b0;
        tick();
        bus.filler_valid = 1'b0;
        beats = 0;
        cyc   = 0;
        while (beats < 12 && cyc < 100) begin
            rdy = (cyc % 2 == 0);
            bus.wr_ready = rdy;
            total++; if (bus.wr_valid !== 1'b1 || bus.wr_addr !== exp_addr(beats % 4, beats / 4) || bus.wr_data !== 32'h00FF0000) begin
                bad++; $display("FAIL bp_beat cyc=%0d valid=%b addr=%h data=%h want 1/%h/00ff0000",
                                cyc, bus.wr_valid, bus.wr_addr, bus.wr_data, exp_addr(beats % 4, beats / 4));
            end
            tick();
            if (rdy) beats++;
            cyc++;
        end
        bus.wr_ready = 1'b1;
        total++; if (cyc != 23) begin bad++; $display("FAIL bp_cycles got=%0d want=23", cyc); end
        total++; if (bus.filler_ready !== 1'b1 || bus.wr_valid !== 1'b0) begin
            bad++; $display("FAIL bp_end ready=%b valid=%b want 1/0", bus.filler_ready, bus.wr_valid);
        end
    endtask

    task automatic test_held_valid();
        int beats;
        bus.filler_color = 24'hFF0000;
        bus.filler_valid = 1'b1;
        bus.wr_ready     = 1'b1;
        tick();
        bus.filler_color = 24'h00FF00;
        for (int i = 0; i < 12; i++) begin
            total++; if (bus.wr_data !== 32'h00FF0000 || bus.filler_ready !== 1'b0 || bus.wr_addr !== exp_addr(i % 4, i / 4)) begin
                bad++; $display("FAIL held_beat beat=%0d data=%h ready=%b addr=%h want 00ff0000/0/%h",
                                i, bus.wr_data, bus.filler_ready, bus.wr_addr, exp_addr(i % 4, i / 4));
            end
            tick();
        end
        total++; if (bus.filler_ready !== 1'b1 || bus.wr_valid !== 1'b0) begin
            bad++; $display("FAIL held_gap ready=%b valid=%b want 1/0", bus.filler_ready, bus.wr_valid);
        end
        tick();
        bus.filler_valid = 1'b0;
        total++; if (bus.wr_valid !== 1'b1 || bus.wr_data !== 32'h0000FF00 || bus.wr_addr !== BASE) begin
            bad++; $display("FAIL held_second valid=%b data=%h addr=%h want 1/0000ff00/%h", bus.wr_valid, bus.wr_data, bus.wr_addr, BASE);
        end
        beats = 0;
        for (int c = 0; c < 30 && bus.filler_ready !== 1'b1; c++) begin
            tick();
            beats++;
        end
        total++; if (beats != 12) begin bad++; $display("FAIL held_second_beats got=%0d want=12", beats); end
    endtask

    task automatic test_reset_mid_fill();
        int beats;
        bus.filler_color = 24'hFF0000;
        bus.filler_valid = 1'b1;
        bus.wr_ready     = 1'b1;
        tick();
        bus.filler_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++; if (bus.wr_valid !== 1'b1 || bus.wr_addr !== exp_addr(1, 1)) begin
            bad++; $display("FAIL mid_pre valid=%b addr=%h want 1/%h", bus.wr_valid, bus.wr_addr, exp_addr(1, 1));
        end
        rst = 1'b1;
        #1;
        total++; if (bus.wr_valid !== 1'b0 || bus.filler_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL mid_rst valid=%b ready=%b busy=%b want 0/1/0", bus.wr_valid, bus.filler_ready, bus.busy);
        end
        tick();
        rst = 1'b0;
        tick();
        bus.filler_color = 24'h123456;
        bus.filler_valid = 1'b1;
        tick();
        bus.filler_valid = 1'b0;
        total++; if (bus.wr_valid !== 1'b1 || bus.wr_addr !== BASE || bus.wr_data !== 32'h00123456) begin
            bad++; $display("FAIL mid_restart valid=%b addr=%h data=%h want 1/%h/00123456", bus.wr_valid, bus.wr_addr, bus.wr_data, BASE);
        end
        beats = 0;
        for (int c = 0; c < 30 && bus.filler_ready !== 1'b1; c++) begin
            tick();
            beats++;
        end
        total++; if (beats != 12) begin bad++; $display("FAIL mid_restart_beats got=%0d want=12", beats); end
    endtask

`ifdef FILLER_RECT_EN
    task automatic test_rect_swap();
        logic [31:0] want [3];
        want[0] = 32'h1000_2004;
        want[1] = 32'h1000_2008;
        want[2] = 32'h1000_200C;
        bus.filler_x0 = 10'd3; bus.filler_x1 = 10'd1;
        bus.filler_y0 = 10'd2; bus.filler_y1 = 10'd2;
        bus.filler_color = 24'h0000FF;
        bus.filler_valid = 1'b1;
        bus.wr_ready     = 1'b1;
        tick();
        bus.filler_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.wr_valid !== 1'b1 || bus.wr_addr !== want[i]) begin
                bad++; $display("FAIL rect_addr beat=%0d valid=%b addr=%h want 1/%h", i, bus.wr_valid, bus.wr_addr, want[i]);
            end
            tick();
        end
        total++; if (bus.filler_ready !== 1'b1 || bus.wr_valid !== 1'b0) begin
            bad++; $display("FAIL rect_end ready=%b valid=%b want 1/0", bus.filler_ready, bus.wr_valid);
        end
    endtask

    task automatic test_rect_clamp();
        bus.filler_x0 = 10'd2; bus.filler_x1 = 10'd1000;
        bus.filler_y0 = 10'd1; bus.filler_y1 = 10'd1;
        bus.filler_valid = 1'b1;
        tick();
        bus.filler_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++; if (bus.wr_valid !== 1'b1 || bus.wr_addr !== exp_addr(2 + i, 1)) begin
                bad++; $display("FAIL clamp_addr beat=%0d valid=%b addr=%h want 1/%h", i, bus.wr_valid, bus.wr_addr, exp_addr(2 + i, 1));
            end
            tick();
        end
        total++; if (bus.filler_ready !== 1'b1 || bus.wr_valid !== 1'b0) begin
            bad++; $display("FAIL clamp_end ready=%b valid=%b want 1/0", bus.filler_ready, bus.wr_valid);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.filler_color = 24'h0;
        bus.filler_valid = 1'b0;
        bus.wr_ready     = 1'b0;
`ifdef FILLER_RECT_EN
        bus.filler_x0 = 10'd0;
        bus.filler_y0 = 10'd0;
        bus.filler_x1 = 10'd0;
        bus.filler_y1 = 10'd0;
`endif
        test_reset();
        test_full_fill();
        test_backpressure();
        test_held_valid();
        test_reset_mid_fill();
`ifdef FILLER_RECT_EN
        test_rect_swap();
        test_rect_clamp();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
